// File: rtl/hazard_scoreboard_mc.sv
// Decode-stage hazard scoreboard with per-register pending-write counters and a branch-shadow FSM.
// Define SCOREBOARD_WB_BYPASS_EN to let same-cycle retires clear a source hazard.
module hazard_scoreboard_mc #(
  parameter int NUM_REGS  = 8,
  parameter int REG_IDX_W = 3,
  parameter int CNT_W     = 2,
  parameter int NUM_WB    = 2,
  parameter int BR_SHADOW = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic                        id_uses_sr1,
  input  logic                        id_uses_sr2,
  input  logic                        id_uses_sr3,
  input  logic [REG_IDX_W-1:0]        id_sr1,
  input  logic [REG_IDX_W-1:0]        id_sr2,
  input  logic [REG_IDX_W-1:0]        id_sr3,
  input  logic                        id_uses_dest,
  input  logic [REG_IDX_W-1:0]        id_dest,
  input  logic                        id_is_ctrl,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*REG_IDX_W-1:0] wb_dest,
  input  logic                        squash_valid,
  input  logic [REG_IDX_W-1:0]        squash_dest,
  input  logic                        br_resolved,
  input  logic                        imem_miss,
  input  logic                        dmem_miss,
  output logic                        issue,
  output logic                        stall_data,
  output logic                        stall_sat,
  output logic                        stall_branch,
  output logic                        insert_nop,
  output logic                        load_front,
  output logic                        load_back,
  output logic [NUM_REGS-1:0]         reg_valid,
  output logic                        err_underflow
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StShadow} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [CNT_W-1:0] pending_q [NUM_REGS];
  logic [CNT_W-1:0] pending_d [NUM_REGS];
  logic             err_q, err_d;
  int               ret_cnt [NUM_REGS];
  int               nxt [NUM_REGS];
  logic [NUM_REGS-1:0] reg_ready;

  // Retire/squash hits per register; the back end re-presents them after a miss.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      ret_cnt[r] = 0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && int'(wb_dest[k*REG_IDX_W +: REG_IDX_W]) == r) ret_cnt[r] += 1;
      end
      if (squash_valid && int'(squash_dest) == r) ret_cnt[r] += 1;
      if (dmem_miss) ret_cnt[r] = 0;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      reg_valid[r] = (pending_q[r] == '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
      reg_ready[r] = (pending_q[r] == '0) || (int'(pending_q[r]) == ret_cnt[r]);
`else
      reg_ready[r] = (pending_q[r] == '0);
`endif
    end
  end

  always_comb begin
    stall_data = 1'b0;
    if (id_valid) begin
      if (id_uses_sr1 && int'(id_sr1) < NUM_REGS && !reg_ready[id_sr1]) stall_data = 1'b1;
      if (id_uses_sr2 && int'(id_sr2) < NUM_REGS && !reg_ready[id_sr2]) stall_data = 1'b1;
      if (id_uses_sr3 && int'(id_sr3) < NUM_REGS && !reg_ready[id_sr3]) stall_data = 1'b1;
    end
    stall_sat = id_valid && id_uses_dest && int'(id_dest) < NUM_REGS &&
                (pending_q[id_dest] == CntMax);
  end

  assign stall_branch  = (state_q == StShadow);
  assign issue         = id_valid & ~stall_data & ~stall_sat & ~stall_branch & ~imem_miss &
                         ~dmem_miss;
  assign insert_nop    = ~issue;
  assign load_front    = issue | (~id_valid & ~imem_miss & ~dmem_miss & ~stall_branch);
  assign load_back     = ~dmem_miss;
  assign err_underflow = err_q;

  // Net delta is applied once, so a same-cycle +1/-1 leaves the counter untouched.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      nxt[r] = int'(pending_q[r]) - ret_cnt[r];
      if (issue && id_uses_dest && int'(id_dest) == r) nxt[r] += 1;
      if (nxt[r] < 0) begin
        nxt[r] = 0;
        err_d  = 1'b1;
      end
      pending_d[r] = CNT_W'(nxt[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) pending_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pending_q[r] <= pending_d[r];
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue && id_is_ctrl) begin
            state_q <= StShadow;
            cnt_q   <= 4'(BR_SHADOW);
          end
        end
        StShadow: begin
          if (br_resolved) begin
            state_q <= StIdle;
          end else if (!dmem_miss) begin
            if (cnt_q == 4'd1) state_q <= StIdle;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_mc.sv
// Directed self-checking bench for hazard_scoreboard_mc (default parameters).
module tb_hazard_scoreboard_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_sr1, id_uses_sr2, id_uses_sr3;
  logic [2:0] id_sr1, id_sr2, id_sr3;
  logic       id_uses_dest;
  logic [2:0] id_dest;
  logic       id_is_ctrl;
  logic [1:0] wb_valid;
  logic [5:0] wb_dest;
  logic       squash_valid;
  logic [2:0] squash_dest;
  logic       br_resolved, imem_miss, dmem_miss;
  logic       issue, stall_data, stall_sat, stall_branch, insert_nop, load_front, load_back;
  logic [7:0] reg_valid;
  logic       err_underflow;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  hazard_scoreboard_mc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_uses_sr1  (id_uses_sr1),
    .id_uses_sr2  (id_uses_sr2),
    .id_uses_sr3  (id_uses_sr3),
    .id_sr1       (id_sr1),
    .id_sr2       (id_sr2),
    .id_sr3       (id_sr3),
    .id_uses_dest (id_uses_dest),
    .id_dest      (id_dest),
    .id_is_ctrl   (id_is_ctrl),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .squash_valid (squash_valid),
    .squash_dest  (squash_dest),
    .br_resolved  (br_resolved),
    .imem_miss    (imem_miss),
    .dmem_miss    (dmem_miss),
    .issue        (issue),
    .stall_data   (stall_data),
    .stall_sat    (stall_sat),
    .stall_branch (stall_branch),
    .insert_nop   (insert_nop),
    .load_front   (load_front),
    .load_back    (load_back),
    .reg_valid    (reg_valid),
    .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    id_valid = 0; id_uses_sr1 = 0; id_uses_sr2 = 0; id_uses_sr3 = 0;
    id_sr1 = 0; id_sr2 = 0; id_sr3 = 0; id_uses_dest = 0; id_dest = 0; id_is_ctrl = 0;
    wb_valid = 0; wb_dest = 0; squash_valid = 0; squash_dest = 0;
    br_resolved = 0; imem_miss = 0; dmem_miss = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic writer(input logic [2:0] d);
    idle_in(); id_valid = 1; id_uses_dest = 1; id_dest = d;
  endtask

  // Issues a control instruction, then counts cycles with stall_branch high.
  task automatic shadow_run(input int miss_at, input int res_at, output int cnt);
    cyc(); idle_in(); id_valid = 1; id_is_ctrl = 1; #1;
    chk("br_issue", 32'(issue), 32'd1);
    cyc(); idle_in(); id_valid = 1; #1;
    chk("shadow_blocks_issue", 32'(issue), 32'd0);
    chk("shadow_load_front", 32'(load_front), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stall_branch) break;
      cnt++;
      dmem_miss   = (cnt == miss_at);
      br_resolved = (cnt == res_at);
      cyc(); idle_in(); #1;
    end
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    #12;
    chk("rst_reg_valid", 32'(reg_valid), 32'hFF);
    chk("rst_stall_branch", 32'(stall_branch), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    chk("rst_insert_nop", 32'(insert_nop), 32'd1);
    chk("rst_load_front", 32'(load_front), 32'd1);
    chk("rst_load_back", 32'(load_back), 32'd1);
    rst_n = 1;

    // Reset mid-operation: pending[3]=2 and shadow active.
    cyc(); writer(3'd3); #1;
    chk("r3_issue_a", 32'(issue), 32'd1);
    cyc(); #1;
    chk("r3_issue_b", 32'(issue), 32'd1);
    chk("r3_pending1", 32'(reg_valid), 32'hF7);
    cyc(); idle_in(); id_valid = 1; id_is_ctrl = 1; #1;
    chk("r3_pending2", 32'(reg_valid), 32'hF7);
    chk("ctrl_issue", 32'(issue), 32'd1);
    cyc(); idle_in(); #1;
    chk("pre_rst_shadow", 32'(stall_branch), 32'd1);
    rst_n = 0; #1;
    chk("async_rst_reg_valid", 32'(reg_valid), 32'hFF);
    chk("async_rst_shadow", 32'(stall_branch), 32'd0);
    chk("async_rst_err", 32'(err_underflow), 32'd0);
    rst_n = 1;

    // Two writers to R1, both retired on the two ports in one cycle.
    cyc(); writer(3'd1); #1;
    chk("r1_issue_a", 32'(issue), 32'd1);
    cyc(); #1;
    chk("r1_issue_b", 32'(issue), 32'd1);
    cyc(); idle_in(); wb_valid = 2'b11; wb_dest = {3'd1, 3'd1}; #1;
    chk("r1_pending2", 32'(reg_valid), 32'hFD);
    cyc(); idle_in(); #1;
    chk("r1_double_retire", 32'(reg_valid), 32'hFF);
    chk("r1_no_err", 32'(err_underflow), 32'd0);

    // Saturation on R2.
    for (int i = 0; i < 3; i++) begin
      cyc(); writer(3'd2); #1;
      chk("r2_fill_issue", 32'(issue), 32'd1);
    end
    cyc(); #1;
    chk("sat_stall", 32'(stall_sat), 32'd1);
    chk("sat_issue", 32'(issue), 32'd0);
    chk("sat_nop", 32'(insert_nop), 32'd1);
    chk("sat_load_front", 32'(load_front), 32'd0);
    cyc(); wb_valid = 2'b01; wb_dest = {3'd0, 3'd2}; #1;
    chk("sat_hold", 32'(stall_sat), 32'd1);
    cyc(); wb_valid = 2'b00; #1;
    chk("sat_release", 32'(stall_sat), 32'd0);
    chk("sat_release_issue", 32'(issue), 32'd1);
    cyc(); idle_in(); wb_valid = 2'b11; wb_dest = {3'd2, 3'd2}; #1;
    cyc(); idle_in(); wb_valid = 2'b01; wb_dest = {3'd0, 3'd2}; #1;
    cyc(); idle_in(); #1;
    chk("r2_drained", 32'(reg_valid), 32'hFF);

    // RAW on R4, with and without a same-cycle retire.
    cyc(); writer(3'd4); #1;
    cyc(); idle_in(); id_valid = 1; id_sr1 = 3'd4; #1;
    chk("unused_src_no_stall", 32'(stall_data), 32'd0);
    id_uses_sr3 = 1; id_sr3 = 3'd4; id_sr1 = 3'd0; #1;
    chk("raw_stall", 32'(stall_data), 32'd1);
    chk("raw_issue", 32'(issue), 32'd0);
    cyc(); idle_in(); id_valid = 1; id_uses_sr1 = 1; id_sr1 = 3'd4;
    wb_valid = 2'b01; wb_dest = {3'd0, 3'd4}; #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("bypass_issue", 32'(issue), 32'd1);
`else
    chk("bypass_issue", 32'(issue), 32'd0);
    cyc(); idle_in(); id_valid = 1; id_uses_sr1 = 1; id_sr1 = 3'd4; #1;
    chk("raw_cleared_issue", 32'(issue), 32'd1);
`endif
    cyc(); idle_in(); #1;
    chk("r4_clear", 32'(reg_valid), 32'hFF);

    // Branch shadow lengths.
    shadow_run(0, 0, n);
    chk("shadow_len_plain", 32'(n), 32'd3);
    shadow_run(2, 0, n);
    chk("shadow_len_miss", 32'(n), 32'd4);
    shadow_run(0, 1, n);
    chk("shadow_len_resolved", 32'(n), 32'd1);

    // Underflow on R5, sticky error.
    cyc(); idle_in(); wb_valid = 2'b01; wb_dest = {3'd0, 3'd5}; #1;
    cyc(); idle_in(); #1;
    chk("uf_err", 32'(err_underflow), 32'd1);
    chk("uf_clamp", 32'(reg_valid), 32'hFF);
    cyc(); #1;
    chk("uf_sticky", 32'(err_underflow), 32'd1);

    // Squash frozen by dmem_miss, then accepted.
    cyc(); writer(3'd6); #1;
    cyc(); idle_in(); id_valid = 1; squash_valid = 1; squash_dest = 3'd6; dmem_miss = 1; #1;
    chk("miss_load_back", 32'(load_back), 32'd0);
    chk("miss_issue", 32'(issue), 32'd0);
    cyc(); idle_in(); #1;
    chk("squash_frozen", 32'(reg_valid), 32'hBF);
    squash_valid = 1; squash_dest = 3'd6;
    cyc(); idle_in(); #1;
    chk("squash_applied", 32'(reg_valid), 32'hFF);

    // Same-cycle issue and retire on R7 cancel out.
    cyc(); writer(3'd7); wb_valid = 2'b10; wb_dest = {3'd7, 3'd0}; #1;
    cyc(); idle_in(); #1;
    chk("net_zero_r7", 32'(reg_valid), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
